slave_ready_valid_hs: RTL and testbench

Receiving end of the team's 8-bit ready/valid handshake. It accepts words from the ready/valid source into a small FIFO and applies backpressure through `s_ready` when that FIFO is full. It drains the FIFO to a downstream sink at a programmable pace, so the bench can exercise both stall and streaming behaviour of the source. It sits directly opposite the source on the same `aclk` domain.

---
 rtl/slave_ready_valid_hs.sv | 107 ++++++++++
 tb/tb_slave_ready_valid_hs.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_ready_valid_hs.sv
// Ready/valid sink: FIFO with backpressure, drained at a fixed programmable pace.
// Optional stats ports (xfer_cnt, checksum) enabled by defining SLAVE_RV_STATS_EN.
module slave_ready_valid_hs #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int DRAIN_DIV = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              aclk,
  input  logic              rstn,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [LW-1:0]     fill_level
`ifdef SLAVE_RV_STATS_EN
  ,
  output logic [15:0]       xfer_cnt,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PW-1:0]     pace;
  logic [LW-1:0]     level_nxt;
  logic              terminal;
  logic              push;
  logic              pop;

  assign terminal = (pace == PW'(DRAIN_DIV - 1));
  assign push     = m_valid && s_ready;
  assign pop      = terminal && (fill_level != '0);

  always_comb begin
    level_nxt = fill_level + LW'(push) - LW'(pop);
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (push && !pop) state_nxt = PARTIAL;
      end
      PARTIAL: begin
        if (level_nxt == LW'(DEPTH)) state_nxt = FULL;
        else if (level_nxt == '0) state_nxt = EMPTY;
      end
      FULL: begin
        if (pop) state_nxt = PARTIAL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= m_data;
  end

  always_ff @(posedge aclk) begin
    if (!rstn) begin
      state      <= EMPTY;
      s_ready    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      fill_level <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pace       <= '0;
    end else begin
      state      <= state_nxt;
      s_ready    <= (state_nxt != FULL);
      fill_level <= level_nxt;
      pace       <= terminal ? '0 : pace + PW'(1);
      out_valid  <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
    end
  end

`ifdef SLAVE_RV_STATS_EN
  always_ff @(posedge aclk) begin
    if (!rstn) begin
      xfer_cnt <= '0;
      checksum <= '0;
    end else if (push) begin
      xfer_cnt <= xfer_cnt + 16'd1;
      checksum <= checksum + m_data;
    end
  end
`endif

endmodule

// File: tb/tb_slave_ready_valid_hs.sv
// Directed bench: DUT a paces at 4 cycles, DUT b drains every cycle.
// Stats checks compile only when SLAVE_RV_STATS_EN is defined.
module tb_slave_ready_valid_hs;

  logic       clk = 1'b0;
  logic       rstn;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic [7:0] a_out;
  logic       a_ov;
  logic [2:0] a_fill;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic [7:0] b_out;
  logic       b_ov;
  logic [2:0] b_fill;
`ifdef SLAVE_RV_STATS_EN
  logic [15:0] a_cnt;
  logic [7:0]  a_sum;
  logic [15:0] b_cnt;
  logic [7:0]  b_sum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  slave_ready_valid_hs #(.DATA_W(8), .DEPTH(4), .DRAIN_DIV(4)) dut_a (
    .aclk(clk), .rstn(rstn),
    .m_valid(a_valid), .m_data(a_data),
    .s_ready(a_ready), .out_data(a_out),
    .out_valid(a_ov), .fill_level(a_fill)
`ifdef SLAVE_RV_STATS_EN
    , .xfer_cnt(a_cnt), .checksum(a_sum)
`endif
  );

  slave_ready_valid_hs #(.DATA_W(8), .DEPTH(4), .DRAIN_DIV(1)) dut_b (
    .aclk(clk), .rstn(rstn),
    .m_valid(b_valid), .m_data(b_data),
    .s_ready(b_ready), .out_data(b_out),
    .out_valid(b_ov), .fill_level(b_fill)
`ifdef SLAVE_RV_STATS_EN
    , .xfer_cnt(b_cnt), .checksum(b_sum)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    a_valid = 1'b1;
    a_data = 8'h10;
    b_valid = 1'b0;
    b_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (a_ready !== 1'b0 || a_fill !== 3'd0 || a_ov !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: ready=%b fill=%0d ov=%b, need 0/0/0",
                 i, a_ready, a_fill, a_ov);
      end
    end
    rstn = 1'b1;
    step();
    n_checks++;
    if (a_ready !== 1'b1 || a_fill !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b fill=%0d, need 1/0",
               a_ready, a_fill);
    end
  endtask

  task automatic test_simul_push_pop;
    a_data = 8'h10;
    step();
    n_checks++;
    if (a_fill !== 3'd1 || a_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL first_push: fill=%0d ov=%b, need 1/0", a_fill, a_ov);
    end
    a_data = 8'h11;
    step();
    n_checks++;
    if (a_fill !== 3'd2 || a_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL second_push: fill=%0d ov=%b, need 2/0", a_fill, a_ov);
    end
    a_data = 8'h12;
    step();
    n_checks++;
    if (a_fill !== 3'd2 || a_ov !== 1'b1 || a_out !== 8'h10) begin
      n_fail++;
      $display("FAIL push_pop_l2: fill=%0d ov=%b out=%h, need 2/1/10",
               a_fill, a_ov, a_out);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_q [4];
    int k;
    a_data = 8'h13;
    step();
    n_checks++;
    if (a_fill !== 3'd3 || a_ready !== 1'b1 || a_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL level3: fill=%0d ready=%b ov=%b, need 3/1/0",
               a_fill, a_ready, a_ov);
    end
    a_data = 8'h14;
    step();
    n_checks++;
    if (a_fill !== 3'd4 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drop: fill=%0d ready=%b, need 4/0", a_fill, a_ready);
    end
    a_data = 8'h15;
    step();
    n_checks++;
    if (a_fill !== 3'd4 || a_ready !== 1'b0 || a_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hold: fill=%0d ready=%b ov=%b, need 4/0/0",
               a_fill, a_ready, a_ov);
    end
    step();
    n_checks++;
    if (a_fill !== 3'd3 || a_ready !== 1'b1 ||
        a_ov !== 1'b1 || a_out !== 8'h11) begin
      n_fail++;
      $display("FAIL pop_rise: fill=%0d ready=%b ov=%b out=%h, need 3/1/1/11",
               a_fill, a_ready, a_ov, a_out);
    end
    step();
    n_checks++;
    if (a_fill !== 3'd4 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL refill: fill=%0d ready=%b, need 4/0", a_fill, a_ready);
    end
    a_valid = 1'b0;
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      step();
      if (a_ov === 1'b1) begin
        n_checks++;
        if (a_out !== exp_q[k]) begin
          n_fail++;
          $display("FAIL drain[%0d]: out=%h, need %h", k, a_out, exp_q[k]);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 4 || a_fill !== 3'd0 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_done: words=%0d fill=%0d ready=%b, need 4/0/1",
               k, a_fill, a_ready);
    end
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 9; i++) begin
      b_valid = (i < 8);
      b_data = 8'(i + 1);
      step();
      n_checks++;
      if (b_fill > 3'd1) begin
        n_fail++;
        $display("FAIL stream_fill[%0d]: fill=%0d, need <=1", i, b_fill);
      end
      n_checks++;
      if (i == 0) begin
        if (b_ov !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_first: ov=%b, need 0", b_ov);
        end
      end else if (b_ov !== 1'b1 || b_out !== 8'(i)) begin
        n_fail++;
        $display("FAIL stream[%0d]: ov=%b out=%h, need 1/%h",
                 i, b_ov, b_out, 8'(i));
      end
    end
    b_valid = 1'b0;
    step();
    n_checks++;
    if (b_fill !== 3'd0 || b_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: fill=%0d ov=%b, need 0/0", b_fill, b_ov);
    end
  endtask

  task automatic test_reset_mid;
    logic got;
    rstn = 1'b0;
    a_valid = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = 8'hA0 + 8'(i);
      step();
    end
    a_valid = 1'b0;
    n_checks++;
    if (a_fill !== 3'd3 || a_out !== 8'hA0) begin
      n_fail++;
      $display("FAIL mid_setup: fill=%0d out=%h, need 3/a0", a_fill, a_out);
    end
    rstn = 1'b0;
    step();
    n_checks++;
    if (a_ready !== 1'b0 || a_ov !== 1'b0 ||
        a_out !== 8'h00 || a_fill !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b ov=%b out=%h fill=%0d, need 0/0/00/0",
               a_ready, a_ov, a_out, a_fill);
    end
    step();
    rstn = 1'b1;
    a_valid = 1'b1;
    a_data = 8'hB0;
    step();
    step();
    a_data = 8'hB1;
    step();
    a_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (a_ov === 1'b1) got = 1'b1;
      else step();
    end
    n_checks++;
    if (!got || a_out !== 8'hB0) begin
      n_fail++;
      $display("FAIL mid_first_out: seen=%b out=%h, need 1/b0", got, a_out);
    end
  endtask

`ifdef SLAVE_RV_STATS_EN
  task automatic test_stats;
    logic [7:0] words [3];
    words = '{8'hF0, 8'h20, 8'h05};
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1;
      b_data = words[i];
      step();
    end
    b_valid = 1'b0;
    step();
    n_checks++;
    if (b_cnt !== 16'd3 || b_sum !== 8'h15) begin
      n_fail++;
      $display("FAIL stats: cnt=%0d sum=%h, need 3/15", b_cnt, b_sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_simul_push_pop();
    test_backpressure();
    test_streaming();
    test_reset_mid();
`ifdef SLAVE_RV_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
